// File: rtl/laser_controller_pkg.sv
// rtl/laser_controller_pkg.sv - shared constants and state encoding for the laser controller
package laser_controller_pkg;

    localparam int PROJ_WIDTH_SCALED  = 2;
    localparam int PROJ_HEIGHT_SCALED = 8;
    localparam int RES_H              = 640;
    localparam int RES_V              = 480;

    localparam int DEF_LASER_SPEED     = 4;
    localparam int DEF_COOLDOWN_FRAMES = 2;
    localparam int DEF_PLAYER_W        = 26;

    // Wide enough for any practical cooldown length
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_FLIGHT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } laser_state_t;

endpackage

// File: rtl/laser_controller_sync_edge.sv
// rtl/laser_controller_sync_edge.sv - two-flop button synchronizer with rising-edge detect
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic v1;
    logic v2;
    logic prev;

    // Synchronizer flops plus a valid pipe; prev holds high until the synchronized
    // level is trustworthy so a button held through reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            prev <= 1'b1;
        end else begin
            s1   <= din;
            s2   <= s1;
            v1   <= 1'b1;
            v2   <= v1;
            prev <= v2 ? s2 : 1'b1;
        end
    end

    assign rise = v2 & s2 & ~prev;

endmodule

// File: rtl/laser_controller.sv
// rtl/laser_controller.sv - player laser launch, flight, hit/miss retirement and cooldown
module laser_controller
    import laser_controller_pkg::*;
#(
    parameter int LASER_SPEED     = DEF_LASER_SPEED,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int PLAYER_W        = DEF_PLAYER_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame,
    input  logic       fire,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [5:0] invader_collision,
    output logic       laser_active,
    output logic [9:0] laser_x,
    output logic [9:0] laser_y,
    output logic       hit,
    output logic [5:0] hit_mask
);

    localparam logic [9:0]       SPEED   = 10'(LASER_SPEED);
    localparam logic [9:0]       PROJ_H  = 10'(PROJ_HEIGHT_SCALED);
    localparam logic [10:0]      HALF_PW = 11'(PLAYER_W / 2);
    localparam logic [10:0]      HALF_LW = 11'(PROJ_WIDTH_SCALED / 2);
    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_FRAMES);

    laser_state_t     state, state_nx;
    logic             pending, pending_nx;
    logic             active_nx;
    logic [9:0]       x_nx, y_nx;
    logic             hit_nx;
    logic [5:0]       mask_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    logic             fire_evt;
    logic [10:0]      x_sum;
    logic [10:0]      x_off;
    logic [9:0]       launch_x;
    logic [9:0]       launch_y;

    sync_edge u_fire_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (fire),
        .rise  (fire_evt)
    );

    // Launch point centred over the player; clamps at both ends instead of wrapping
    assign x_sum    = {1'b0, player_x} + HALF_PW;
    assign x_off    = x_sum - HALF_LW;
    assign launch_x = (x_sum < HALF_LW) ? 10'd0 : (x_off[10] ? 10'h3ff : x_off[9:0]);
    assign launch_y = (player_y < PROJ_H) ? 10'd0 : player_y - PROJ_H;

    // Next-state and next-output decode; collisions take priority over frame motion
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        active_nx  = laser_active;
        x_nx       = laser_x;
        y_nx       = laser_y;
        hit_nx     = 1'b0;
        mask_nx    = hit_mask;
        cnt_nx     = cnt;
        case (state)
            ST_READY: begin
                if (frame && (pending || fire_evt)) begin
                    pending_nx = 1'b0;
                    state_nx   = ST_FLIGHT;
                    active_nx  = 1'b1;
                    x_nx       = launch_x;
                    y_nx       = launch_y;
                end else if (fire_evt) begin
                    pending_nx = 1'b1;
                end
            end
            ST_FLIGHT: begin
                if (invader_collision != 6'd0) begin
                    active_nx = 1'b0;
                    hit_nx    = 1'b1;
                    mask_nx   = invader_collision;
                    state_nx  = ST_COOLDOWN;
                    cnt_nx    = CD_LOAD;
                end else if (frame) begin
                    if (laser_y < SPEED) begin
                        active_nx = 1'b0;
                        state_nx  = ST_COOLDOWN;
                        cnt_nx    = CD_LOAD;
                    end else begin
                        y_nx = laser_y - SPEED;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (cnt == '0) begin
                    state_nx = ST_READY;
                end else if (frame) begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx  = ST_READY;
                active_nx = 1'b0;
            end
        endcase
    end

    // State and registered outputs, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_READY;
            pending      <= 1'b0;
            laser_active <= 1'b0;
            laser_x      <= 10'd0;
            laser_y      <= 10'd0;
            hit          <= 1'b0;
            hit_mask     <= 6'd0;
            cnt          <= '0;
        end else begin
            state        <= state_nx;
            pending      <= pending_nx;
            laser_active <= active_nx;
            laser_x      <= x_nx;
            laser_y      <= y_nx;
            hit          <= hit_nx;
            hit_mask     <= mask_nx;
            cnt          <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_laser_controller.sv
// tb/tb_laser_controller.sv - self-checking bench for laser_controller
module tb_laser_controller;

    localparam int SPEED = 4;
    localparam int COOL  = 2;
    localparam int PW    = 26;
    localparam int LW    = 2;
    localparam int LH    = 8;

    logic       clk;
    logic       rst_n;
    logic       frame;
    logic       fire;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [5:0] invader_collision;
    logic       laser_active;
    logic [9:0] laser_x;
    logic [9:0] laser_y;
    logic       hit;
    logic [5:0] hit_mask;

    int total;
    int bad;

    // reference model state
    logic hist[$];
    int   m_x, m_y, m_cool;
    logic m_active, m_hit, m_pend, m_flying;
    logic [5:0] m_mask;

    laser_controller dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frame             (frame),
        .fire              (fire),
        .player_x          (player_x),
        .player_y          (player_y),
        .invader_collision (invader_collision),
        .laser_active      (laser_active),
        .laser_x           (laser_x),
        .laser_y           (laser_y),
        .hit               (hit),
        .hit_mask          (hit_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        m_x = 0; m_y = 0; m_cool = -1;
        m_active = 0; m_hit = 0; m_pend = 0; m_flying = 0; m_mask = '0;
    endtask

    task automatic model_edge();
        int   n;
        logic prev;
        logic evt;
        int   vx;
        hist.push_back(fire);
        n    = hist.size();
        prev = (n >= 4) ? hist[n-4] : 1'b1;
        evt  = (n >= 3) && hist[n-3] && !prev;
        m_hit = 0;
        if (m_flying) begin
            if (invader_collision != 6'd0) begin
                m_flying = 0; m_active = 0; m_hit = 1;
                m_mask = invader_collision; m_cool = COOL;
            end else if (frame) begin
                if (m_y < SPEED) begin
                    m_flying = 0; m_active = 0; m_cool = COOL;
                end else begin
                    m_y = m_y - SPEED;
                end
            end
        end else if (m_cool > 0) begin
            if (frame) m_cool = m_cool - 1;
        end else if (m_cool == 0) begin
            m_cool = -1;
        end else begin
            m_pend = m_pend | evt;
            if (frame && m_pend) begin
                m_pend = 0; m_flying = 1; m_active = 1;
                vx = int'(player_x) + PW / 2 - LW / 2;
                m_x = (vx < 0) ? 0 : ((vx > 1023) ? 1023 : vx);
                m_y = (int'(player_y) >= LH) ? int'(player_y) - LH : 0;
            end
        end
    endtask

    task automatic step(input logic f, input logic fr, input logic [5:0] c);
        @(negedge clk);
        fire = f; frame = fr; invader_collision = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic press_and_launch();
        step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
        step(0, 1, 0);
    endtask

    task automatic settle();
        step(0, 0, 6'h01);
        step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
        step(0, 0, 0); step(0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fire = 0; frame = 0; invader_collision = 0;
        player_x = 0; player_y = 0;
        model_reset();
        #1;
        total += 5;
        if (laser_active !== 1'b0) begin bad++; $display("FAIL reset_active got %0b expected 0", laser_active); end
        if (laser_x !== 10'd0) begin bad++; $display("FAIL reset_x got %0d expected 0", laser_x); end
        if (laser_y !== 10'd0) begin bad++; $display("FAIL reset_y got %0d expected 0", laser_y); end
        if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got %0b expected 0", hit); end
        if (hit_mask !== 6'd0) begin bad++; $display("FAIL reset_mask got %0h expected 0", hit_mask); end
        release_reset();
    endtask

    task automatic test_launch();
        player_x = 10'd300; player_y = 10'd440;
        press_and_launch();
        total += 3;
        if (laser_active !== 1'b1) begin bad++; $display("FAIL launch_active got %0b expected 1", laser_active); end
        if (laser_x !== 10'd312) begin bad++; $display("FAIL launch_x got %0d expected 312", laser_x); end
        if (laser_y !== 10'd432) begin bad++; $display("FAIL launch_y got %0d expected 432", laser_y); end
    endtask

    task automatic test_hit();
        step(0, 0, 0);
        step(0, 1, 6'b000100);
        total += 4;
        if (hit !== 1'b1) begin bad++; $display("FAIL hit_pulse got %0b expected 1", hit); end
        if (hit_mask !== 6'b000100) begin bad++; $display("FAIL hit_mask got %0h expected 04", hit_mask); end
        if (laser_y !== 10'd432) begin bad++; $display("FAIL hit_y got %0d expected 432", laser_y); end
        if (laser_active !== 1'b0) begin bad++; $display("FAIL hit_active got %0b expected 0", laser_active); end
        step(0, 0, 6'b001000);
        total += 2;
        if (hit !== 1'b0) begin bad++; $display("FAIL hit_single got %0b expected 0", hit); end
        if (hit_mask !== 6'b000100) begin bad++; $display("FAIL hit_mask_hold got %0h expected 04", hit_mask); end
        settle();
    endtask

    task automatic test_miss();
        int ys[3] = '{10, 6, 2};
        player_x = 10'd100; player_y = 10'd18;
        press_and_launch();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step(0, 1, 0);
            total += 2;
            if (laser_active !== 1'b1) begin bad++; $display("FAIL miss_active_%0d got %0b expected 1", i, laser_active); end
            if (laser_y !== ys[i][9:0]) begin bad++; $display("FAIL miss_y_%0d got %0d expected %0d", i, laser_y, ys[i]); end
        end
        step(0, 1, 0);
        total += 2;
        if (laser_active !== 1'b0) begin bad++; $display("FAIL miss_retire got %0b expected 0", laser_active); end
        if (hit !== 1'b0) begin bad++; $display("FAIL miss_nohit got %0b expected 0", hit); end
        step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);
        press_and_launch();
        total++;
        if (laser_active !== 1'b1) begin bad++; $display("FAIL miss_rearm got %0b expected 1", laser_active); end
        settle();
    endtask

    task automatic test_spam();
        player_x = 10'd200; player_y = 10'd300;
        press_and_launch();
        for (int i = 0; i < 4; i++) begin step(1, 0, 0); step(0, 1, 0); end
        step(1, 0, 6'h02);
        for (int i = 0; i < 3; i++) begin step(0, 0, 0); step(1, 0, 0); end
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 1, 0); step(0, 1, 0); step(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0);
            total++;
            if (laser_active !== 1'b0) begin bad++; $display("FAIL spam_nolaunch_%0d got %0b expected 0", i, laser_active); end
        end
        press_and_launch();
        total++;
        if (laser_active !== 1'b1) begin bad++; $display("FAIL spam_newpress got %0b expected 1", laser_active); end
        settle();
    endtask

    task automatic test_saturation();
        player_x = 10'd50; player_y = 10'd5;
        press_and_launch();
        total += 3;
        if (laser_active !== 1'b1) begin bad++; $display("FAIL sat_active got %0b expected 1", laser_active); end
        if (laser_y !== 10'd0) begin bad++; $display("FAIL sat_y got %0d expected 0", laser_y); end
        if (laser_x !== 10'd62) begin bad++; $display("FAIL sat_x got %0d expected 62", laser_x); end
        step(0, 1, 0);
        total += 2;
        if (laser_active !== 1'b0) begin bad++; $display("FAIL sat_miss got %0b expected 0", laser_active); end
        if (hit !== 1'b0) begin bad++; $display("FAIL sat_nohit got %0b expected 0", hit); end
        settle();
    endtask

    task automatic test_reset_mid_flight();
        player_x = 10'd400; player_y = 10'd300;
        press_and_launch();
        step(0, 1, 0); step(1, 1, 0); step(1, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        total += 5;
        if (laser_active !== 1'b0) begin bad++; $display("FAIL rmf_active got %0b expected 0", laser_active); end
        if (laser_x !== 10'd0) begin bad++; $display("FAIL rmf_x got %0d expected 0", laser_x); end
        if (laser_y !== 10'd0) begin bad++; $display("FAIL rmf_y got %0d expected 0", laser_y); end
        if (hit !== 1'b0) begin bad++; $display("FAIL rmf_hit got %0b expected 0", hit); end
        if (hit_mask !== 6'd0) begin bad++; $display("FAIL rmf_mask got %0h expected 0", hit_mask); end
        model_reset();
        release_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0);
            total++;
            if (laser_active !== 1'b0) begin bad++; $display("FAIL rmf_held_%0d got %0b expected 0", i, laser_active); end
        end
        step(0, 0, 0);
        press_and_launch();
        total += 2;
        if (laser_active !== 1'b1) begin bad++; $display("FAIL rmf_toggle got %0b expected 1", laser_active); end
        if (laser_y !== 10'd292) begin bad++; $display("FAIL rmf_toggle_y got %0d expected 292", laser_y); end
        settle();
    endtask

    task automatic test_random();
        logic       f;
        logic       fr;
        logic [5:0] c;
        f = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) f = ~f;
            fr = ($urandom_range(2) == 0);
            c  = ($urandom_range(39) == 0) ? 6'($urandom_range(63, 1)) : 6'd0;
            if ($urandom_range(15) == 0) begin
                player_x = 10'($urandom_range(1023));
                player_y = ($urandom_range(3) == 0) ? 10'($urandom_range(12)) : 10'($urandom_range(479));
            end
            step(f, fr, c);
            total += 5;
            if (laser_active !== m_active) begin bad++; $display("FAIL rnd_active cyc %0d got %0b expected %0b", i, laser_active, m_active); end
            if (laser_x !== m_x[9:0]) begin bad++; $display("FAIL rnd_x cyc %0d got %0d expected %0d", i, laser_x, m_x); end
            if (laser_y !== m_y[9:0]) begin bad++; $display("FAIL rnd_y cyc %0d got %0d expected %0d", i, laser_y, m_y); end
            if (hit !== m_hit) begin bad++; $display("FAIL rnd_hit cyc %0d got %0b expected %0b", i, hit, m_hit); end
            if (hit_mask !== m_mask) begin bad++; $display("FAIL rnd_mask cyc %0d got %0h expected %0h", i, hit_mask, m_mask); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_launch();
        test_hit();
        test_miss();
        test_spam();
        test_saturation();
        test_reset_mid_flight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
